// File: rtl/safety_island_err_subordinate.sv
// Purpose: OBI error subordinate. It grants every request aimed at unmapped peripheral space
//          and answers each one in order with err=1 and a fixed rdata pattern. It also logs
//          the first fault (addr/we) and keeps a saturating fault count.
// Latency: 1 cycle minimum from grant to rvalid. Grant is combinational: gnt = req & ~full.
// Backpressure: rready_i low holds the head response. A full ID FIFO drops gnt, including in a popping cycle.
// Ports: OBI request (req/gnt/addr/we/be/wdata/aid), OBI response (rvalid/rready/rdata/err/rid),
//        fault log (clr_i in; err_valid/err_addr/err_we/err_cnt out).
module safety_island_err_subordinate #(
    parameter int unsigned            AddrWidth   = 32,
    parameter int unsigned            DataWidth   = 32,
    parameter int unsigned            IdWidth     = 1,
    parameter int unsigned            NumMaxTrans = 2,
    parameter logic [DataWidth-1:0]   RspData     = 32'hBADC_AB1E,
    parameter int unsigned            CntWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic [IdWidth-1:0]     rid_o,
    input  logic                   clr_i,
    output logic                   err_valid_o,
    output logic [AddrWidth-1:0]   err_addr_o,
    output logic                   err_we_o,
    output logic [CntWidth-1:0]    err_cnt_o
);

    // A depth-1 FIFO still needs a 1-bit pointer.
    localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned OccWidth = $clog2(NumMaxTrans + 1);

    // Byte enables and write data carry no meaning for an error response.
    logic unused_inputs;
    assign unused_inputs = ^{be_i, wdata_i};

    logic [IdWidth-1:0]  id_mem [NumMaxTrans];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [OccWidth-1:0] occ;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    assign full  = (occ == OccWidth'(NumMaxTrans));
    assign empty = (occ == '0);

    // No pass-through when full: a pop in the same cycle does not free a slot until the next cycle.
    assign gnt_o = req_i & ~full;
    assign push  = req_i & gnt_o;
    assign pop   = rvalid_o & rready_i;

    // The response comes only from registered FIFO state, so rvalid and rid hold while rready is low.
    assign rvalid_o = ~empty;
    assign err_o    = ~empty;
    assign rdata_o  = empty ? '0 : RspData;
    assign rid_o    = empty ? '0 : id_mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= aid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrWidth'(NumMaxTrans - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrWidth'(NumMaxTrans - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Fault log. A handshake takes priority over a coincident clear, so the new fault is
    // the one that gets logged, and the count restarts at 1.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_we_o    <= 1'b0;
            err_cnt_o   <= '0;
        end else if (push) begin
            if (clr_i) begin
                err_cnt_o <= CntWidth'(1);
            end else if (err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
            if (clr_i || !err_valid_o) begin
                err_valid_o <= 1'b1;
                err_addr_o  <= addr_i;
                err_we_o    <= we_i;
            end
        end else if (clr_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_we_o    <= 1'b0;
            err_cnt_o   <= '0;
        end
    end

endmodule
